fetch_unit: RTL and testbench

- Fetch stage of the 5-stage pipeline; the producer side of the fetch/decode interface.
- Owns the PC and reads the instruction memory.
- Assembles two-word (instruction + immediate) instructions and presents registered instr/imm/pc/valid to the decode stage.
- Handles stall hold and branch redirect; a redirect squashes any in-flight fetch and emits a NOP bubble.

---
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory and hands registered
// instr/imm/pc/valid to decode, pairing prefix instructions with their immediate.
module fetch_unit #(
    parameter int                W          = 16,
    parameter int                ADDR_W     = 16,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter logic [2:0]        IMM_PREFIX = 3'b110,
    parameter logic [W-1:0]      NOP        = 16'b000101_000_011_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [W-1:0]      imem_data,
    output logic [W-1:0]      instr_out,
    output logic [W-1:0]      imm_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              valid_out
);

    typedef enum logic {
        FETCH,
        FETCH_IMM
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] hold_pc;
    logic [W-1:0]      hold_instr;
    logic              needs_imm;
    logic [ADDR_W-1:0] pc_inc;

    assign imem_addr = pc;
    assign needs_imm = (imem_data[W-1 -: 3] == IMM_PREFIX);
    assign pc_inc    = pc + ADDR_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= FETCH;
            hold_instr <= '0;
            hold_pc    <= '0;
            instr_out  <= NOP;
            imm_out    <= '0;
            pc_out     <= '0;
            valid_out  <= 1'b0;
        end else if (br_taken) begin
            // Redirect wins over stall and drops any half-assembled pair.
            pc        <= br_target;
            state     <= FETCH;
            instr_out <= NOP;
            imm_out   <= '0;
            valid_out <= 1'b0;
        end else if (!stall) begin
            pc <= pc_inc;
            case (state)
                FETCH: begin
                    if (needs_imm) begin
                        hold_instr <= imem_data;
                        hold_pc    <= pc;
                        state      <= FETCH_IMM;
                        instr_out  <= NOP;
                        imm_out    <= '0;
                        valid_out  <= 1'b0;
                    end else begin
                        instr_out <= imem_data;
                        imm_out   <= '0;
                        pc_out    <= pc;
                        valid_out <= 1'b1;
                    end
                end
                FETCH_IMM: begin
                    // Second word is data only; its prefix bits are not inspected.
                    instr_out <= hold_instr;
                    imm_out   <= imem_data;
                    pc_out    <= hold_pc;
                    valid_out <= 1'b1;
                    state     <= FETCH;
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit: a 16-bit-PC and a 4-bit-PC instance
// share one memory and are checked cycle by cycle against a program-order model.
module tb_fetch_unit;

    localparam logic [15:0] NOP = 16'b000101_000_011_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_target = '0;

    logic [15:0] imem_addr, imem_data, instr_out, imm_out, pc_out;
    logic        valid_out;
    logic [3:0]  imem_addr4, pc_out4;
    logic [15:0] imem_data4, instr_out4, imm_out4;
    logic        valid_out4;

    logic [15:0] mem [0:65535];

    assign imem_data  = mem[imem_addr];
    assign imem_data4 = mem[{12'h000, imem_addr4}];

    always #5 clk = ~clk;

    fetch_unit #(.W(16), .ADDR_W(16)) dut (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target),
        .imem_addr(imem_addr), .imem_data(imem_data), .instr_out(instr_out),
        .imm_out(imm_out), .pc_out(pc_out), .valid_out(valid_out)
    );

    fetch_unit #(.W(16), .ADDR_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_target(br_target[3:0]),
        .imem_addr(imem_addr4), .imem_data(imem_data4), .instr_out(instr_out4),
        .imm_out(imm_out4), .pc_out(pc_out4), .valid_out(valid_out4)
    );

    // Model: next address plus an optional pending first word awaiting its immediate.
    typedef struct {
        logic [15:0] pc;
        bit          holding;
        logic [15:0] hi;
        logic [15:0] hp;
        logic [15:0] instr;
        logic [15:0] imm;
        logic [15:0] pco;
        bit          valid;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    exp_t q[$];
    mdl_t ma, mb;
    int   checks = 0;
    int   errors = 0;

    function automatic mdl_t mreset();
        mdl_t m;
        m.pc = 16'h0; m.holding = 0; m.hi = 16'h0; m.hp = 16'h0;
        m.instr = NOP; m.imm = 16'h0; m.pco = 16'h0; m.valid = 0;
        return m;
    endfunction

    function automatic mdl_t mstep(mdl_t m, logic [15:0] mask, bit s, bit b, logic [15:0] t);
        logic [15:0] w;
        w = mem[m.pc];
        if (b) begin
            m.pc = t & mask; m.holding = 0;
            m.instr = NOP; m.imm = 16'h0; m.valid = 0;
        end else if (!s) begin
            if (m.holding) begin
                m.instr = m.hi; m.imm = w; m.pco = m.hp; m.valid = 1; m.holding = 0;
            end else if (w[15:13] == 3'b110) begin
                m.hi = w; m.hp = m.pc; m.holding = 1;
                m.instr = NOP; m.imm = 16'h0; m.valid = 0;
            end else begin
                m.instr = w; m.imm = 16'h0; m.pco = m.pc; m.valid = 1;
            end
            m.pc = (m.pc + 16'h1) & mask;
        end
        return m;
    endfunction

    task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Monitor: the outputs are registered, so every cycle presents one response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL scoreboard_empty at %0t", $time);
            end else begin
                e = q.pop_front();
                chk("imem_addr", imem_addr, e.a.pc);
                chk("instr_out", instr_out, e.a.instr);
                chk("imm_out", imm_out, e.a.imm);
                chk("pc_out", pc_out, e.a.pco);
                chk("valid_out", 16'(valid_out), 16'(e.a.valid));
                chk("w4_imem_addr", {12'h000, imem_addr4}, e.b.pc);
                chk("w4_instr_out", instr_out4, e.b.instr);
                chk("w4_imm_out", imm_out4, e.b.imm);
                chk("w4_pc_out", {12'h000, pc_out4}, e.b.pco);
                chk("w4_valid_out", 16'(valid_out4), 16'(e.b.valid));
            end
        end
    end

    task automatic push();
        exp_t e;
        e.a = ma;
        e.b = mb;
        q.push_back(e);
    endtask

    task automatic hold_rst();
        @(negedge clk); #1;
        rst = 1'b1;
        ma = mreset(); mb = mreset();
        push();
    endtask

    task automatic cyc(input bit s, input bit b, input logic [15:0] t, input bit pulse);
        @(negedge clk); #1;
        if (pulse) begin
            rst = 1'b1;
            ma = mreset(); mb = mreset();
            #1;
            chk("async_rst_instr", instr_out, NOP);
            chk("async_rst_imm", imm_out, 16'h0);
            chk("async_rst_pc_out", pc_out, 16'h0);
            chk("async_rst_valid", 16'(valid_out), 16'h0);
            chk("async_rst_addr", imem_addr, 16'h0);
            chk("async_rst_w4_addr", {12'h000, imem_addr4}, 16'h0);
        end
        rst = 1'b0;
        stall = s; br_taken = b; br_target = t;
        ma = mstep(ma, 16'hFFFF, s, b, t);
        mb = mstep(mb, 16'h000F, s, b, t);
        push();
    endtask

    task automatic run_to_imm();
        int n = 0;
        while (!ma.holding && n < 20) begin
            cyc(0, 0, 16'h0, 0);
            n++;
        end
        checks++;
        if (!ma.holding) begin
            errors++;
            $display("FAIL reach_fetch_imm: got no prefix word within 20 cycles at %0t", $time);
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) begin
            logic [15:0] w;
            w = 16'($urandom);
            if ($urandom_range(3) == 0) w[15:13] = 3'b110;
            else if (w[15:13] == 3'b110) w[15:13] = 3'b000;
            mem[i] = w;
        end
        mem[0]  = 16'h0401; mem[1]  = 16'h0802; mem[2]  = 16'h0C03; mem[3]  = 16'h1003;
        mem[4]  = 16'hC123; mem[5]  = 16'hBEEF; mem[6]  = 16'h1006; mem[7]  = 16'h1007;
        mem[8]  = 16'hD0AA; mem[9]  = 16'hC555; mem[10] = 16'h100A; mem[11] = 16'h100B;
        mem[16'h40] = 16'h2040; mem[16'h41] = 16'h2041;

        ma = mreset(); mb = mreset();
        push();
        hold_rst();
        hold_rst();

        // Straight-line fetch, then the C123/BEEF pair.
        for (int i = 0; i < 8; i++) cyc(0, 0, 16'h0, 0);
        // Stall in FETCH, then a prefix pair whose immediate also looks like a prefix.
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0, 0);
        cyc(0, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) cyc(1, 0, 16'h0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 0);

        // Redirect during FETCH_IMM with stall asserted in the same cycle.
        run_to_imm();
        cyc(1, 1, 16'h0040, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 16'h0, 0);

        // PC wrap at the top of the 16-bit space.
        cyc(0, 1, 16'hFFFD, 0);
        for (int i = 0; i < 6; i++) cyc(0, 0, 16'h0, 0);

        // Asynchronous reset pulse mid two-word fetch.
        run_to_imm();
        cyc(0, 0, 16'h0, 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 16'h0, 0);

        for (int i = 0; i < 500; i++) begin
            bit          s, b, p;
            logic [15:0] t;
            s = ($urandom_range(4) == 0);
            b = ($urandom_range(9) == 0);
            p = ($urandom_range(49) == 0);
            t = ($urandom_range(1) == 1) ? (16'hFFF0 | 16'($urandom_range(15)))
                                         : 16'($urandom_range(127));
            cyc(s, b, t, p);
        end

        @(negedge clk); #2;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
